// File: rtl/branch_hist_queue.sv
// In-order record queue between the fetch-stage history predictor and the
// execute-stage resolver: pops the head on resolve and emits a registered update.
module branch_hist_queue #(
  parameter int DEPTH      = 8,
  parameter int WIDTH_HIST = 10,
  parameter int WIDTH_ADDR = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enq_valid,
  output logic                    enq_ready,
  input  logic [WIDTH_ADDR-1:0]   enq_pc,
  input  logic [WIDTH_HIST-1:0]   enq_hist,
  input  logic                    enq_pred_taken,
  input  logic [WIDTH_ADDR-1:0]   enq_pred_next_pc,
  input  logic                    res_valid,
  input  logic                    res_taken,
  input  logic [WIDTH_ADDR-1:0]   res_next_pc,
  output logic                    upd_valid,
  output logic [WIDTH_ADDR-1:0]   upd_pc,
  output logic [WIDTH_HIST-1:0]   upd_hist,
  output logic                    upd_taken,
  output logic                    mispred,
  output logic [WIDTH_ADDR-1:0]   redirect_pc,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    err_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH_ADDR-1:0] pc_mem    [DEPTH];
  logic [WIDTH_HIST-1:0] hist_mem  [DEPTH];
  logic                  ptkn_mem  [DEPTH];
  logic [WIDTH_ADDR-1:0] pnext_mem [DEPTH];

  logic [PW-1:0]         rptr_q, rptr_d, wptr_q, wptr_d;
  logic                  err_q, err_d;
  logic                  upd_valid_q, mispred_q, upd_taken_q;
  logic [WIDTH_ADDR-1:0] upd_pc_q, redirect_q;
  logic [WIDTH_HIST-1:0] upd_hist_q;

  logic          empty, full, do_enq, do_pop, mis;
  logic [AW-1:0] head, tail;

  assign head   = rptr_q[AW-1:0];
  assign tail   = wptr_q[AW-1:0];
  assign empty  = (wptr_q == rptr_q);
  assign full   = (head == tail) && (wptr_q[AW] != rptr_q[AW]);
  assign do_enq = enq_valid & ~full;
  assign do_pop = res_valid & ~empty;
  assign mis    = do_pop & ((res_next_pc != pnext_mem[head]) |
                            (res_taken != ptkn_mem[head]));

  // A mispredict squashes every younger record, including one arriving now.
  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    err_d  = err_q | (res_valid & empty);
    if (do_pop) rptr_d = rptr_q + PW'(1);
    if (mis) wptr_d = rptr_q + PW'(1);
    else if (do_enq) wptr_d = wptr_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (do_enq && !mis && !reset) begin
      pc_mem[tail]    <= enq_pc;
      hist_mem[tail]  <= enq_hist;
      ptkn_mem[tail]  <= enq_pred_taken;
      pnext_mem[tail] <= enq_pred_next_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr_q      <= '0;
      wptr_q      <= '0;
      err_q       <= 1'b0;
      upd_valid_q <= 1'b0;
      mispred_q   <= 1'b0;
      upd_taken_q <= 1'b0;
      upd_pc_q    <= '0;
      upd_hist_q  <= '0;
      redirect_q  <= '0;
    end else begin
      rptr_q      <= rptr_d;
      wptr_q      <= wptr_d;
      err_q       <= err_d;
      upd_valid_q <= do_pop;
      mispred_q   <= mis;
      // Update payload holds its last value between pops.
      if (do_pop) begin
        upd_pc_q    <= pc_mem[head];
        upd_hist_q  <= hist_mem[head];
        upd_taken_q <= res_taken;
        redirect_q  <= res_next_pc;
      end
    end
  end

  assign enq_ready     = ~full;
  assign count         = wptr_q - rptr_q;
  assign upd_valid     = upd_valid_q;
  assign mispred       = mispred_q;
  assign upd_taken     = upd_taken_q;
  assign upd_pc        = upd_pc_q;
  assign upd_hist      = upd_hist_q;
  assign redirect_pc   = redirect_q;
  assign err_underflow = err_q;

endmodule
